// File: rtl/drowsy_pkg.sv
// Shared types and constants for the drowsiness decision path.
// Class-bit positions match the output-neuron ordering of the upstream network.
package drowsy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    WARN    = 2'd2,
    ALARM   = 2'd3
  } state_t;

  localparam int CLS_ALERT  = 0;
  localparam int CLS_DROWSY = 1;
  localparam int CLS_CLOSED = 2;

  // A frame is trusted only when exactly one class neuron fired.
  function automatic logic is_one_hot3(input logic [2:0] v);
    return (v != 3'b000) && ((v & (v - 3'b001)) == 3'b000);
  endfunction

endpackage

// File: rtl/sliding_window_counter.sv
// Keeps the last WIN frame flags and a running count of the set ones.
// The count tracks the shift register exactly, so it can never wrap.
module sliding_window_counter #(
  parameter int WIN   = 16,
  parameter int CNT_W = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en_i,
  input  logic             bit_in_i,
  output logic [CNT_W-1:0] count_o
);

  logic [WIN-1:0]   win_q, win_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             oldest;

  assign oldest = win_q[WIN-1];

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    win_d   = win_q;
    count_d = count_q;
    if (shift_en_i) begin
      win_d = {win_q[WIN-2:0], bit_in_i};
      if (bit_in_i && !oldest) begin
        count_d = count_q + CNT_W'(1);
      end else if (!bit_in_i && oldest) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // NOTE: the window storage is reset too -- frames not yet seen must read as 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q   <= '0;
      count_q <= '0;
    end else begin
      win_q   <= win_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/drowsy_decision_fsm.sv
// Debounces per-frame drowsiness classes over a sliding window and drives
// latched MONITOR/WARN/ALARM flags with a fixed two-cycle sample-to-flag latency.
module drowsy_decision_fsm
  import drowsy_pkg::*;
#(
  parameter int WIN        = 16,
  parameter int WARN_THR   = 6,
  parameter int ALARM_THR  = 10,
  parameter int CLEAR_THR  = 2,
  parameter int CLOSED_THR = 5,
  parameter int ERR_W      = 8
) (
  input  logic                       Clock,
  input  logic                       Rst,
  input  logic                       sample_valid,
  input  logic [2:0]                 class_in,
  input  logic                       clear_alarm,
  output logic [1:0]                 state,
  output logic                       warn,
  output logic                       alarm,
  output logic [$clog2(WIN+1)-1:0]   win_count,
  output logic [ERR_W-1:0]           err_count
);

  localparam int CNT_W = $clog2(WIN + 1);
  localparam int RUN_W = $clog2(CLOSED_THR + 1);

  state_t           state_q;
  logic             warn_q, alarm_q;
  logic [RUN_W-1:0] closed_run_q;
  logic [ERR_W-1:0] err_count_q;
  logic             seen_valid_q;
  logic [CNT_W-1:0] win_count_w;

  logic frame_ok, frame_flag, shift_en;
  logic go_alarm, at_clear;

  assign frame_ok   = is_one_hot3(class_in);
  assign frame_flag = class_in[CLS_DROWSY] | class_in[CLS_CLOSED];
  assign shift_en   = sample_valid & frame_ok;

  sliding_window_counter #(
    .WIN   (WIN),
    .CNT_W (CNT_W)
  ) u_window (
    .clk        (Clock),
    .rst_n      (Rst),
    .shift_en_i (shift_en),
    .bit_in_i   (frame_flag),
    .count_o    (win_count_w)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      closed_run_q <= '0;
      err_count_q  <= '0;
      seen_valid_q <= 1'b0;
    end else if (sample_valid) begin
      if (frame_ok) begin
        seen_valid_q <= 1'b1;
        if (!class_in[CLS_CLOSED]) begin
          closed_run_q <= '0;
        end else if (closed_run_q != RUN_W'(CLOSED_THR)) begin
          closed_run_q <= closed_run_q + RUN_W'(1);
        end
      end else if (!(&err_count_q)) begin
        err_count_q <= err_count_q + ERR_W'(1);
      end
    end
  end

  // Decisions use only registered counters, so a same-cycle sample never affects a clear.
  assign go_alarm = (closed_run_q == RUN_W'(CLOSED_THR)) ||
                    (win_count_w >= CNT_W'(ALARM_THR));
  assign at_clear = (win_count_w <= CNT_W'(CLEAR_THR));

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state_q <= IDLE;
      warn_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (seen_valid_q) begin
            state_q <= MONITOR;
          end
        end
        MONITOR: begin
          if (go_alarm) begin
            state_q <= ALARM;
            alarm_q <= 1'b1;
          end else if (win_count_w >= CNT_W'(WARN_THR)) begin
            state_q <= WARN;
            warn_q  <= 1'b1;
          end
        end
        WARN: begin
          if (go_alarm) begin
            state_q <= ALARM;
            warn_q  <= 1'b0;
            alarm_q <= 1'b1;
          end else if (at_clear) begin
            state_q <= MONITOR;
            warn_q  <= 1'b0;
          end
        end
        ALARM: begin
          if (clear_alarm && at_clear && (closed_run_q == '0)) begin
            state_q <= MONITOR;
            alarm_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          warn_q  <= 1'b0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign warn      = warn_q;
  assign alarm     = alarm_q;
  assign win_count = win_count_w;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_drowsy_decision_fsm.sv
// Directed bench for drowsy_decision_fsm: window debounce, thresholds, alarm latch,
// invalid-frame accounting and mid-alarm reset.
module tb_drowsy_decision_fsm;
  import drowsy_pkg::*;

  localparam logic [2:0] F_ALERT  = 3'b001;
  localparam logic [2:0] F_DROWSY = 3'b010;
  localparam logic [2:0] F_CLOSED = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_valid;
  logic [2:0] class_in;
  logic       clear_alarm;
  logic [1:0] state;
  logic       warn;
  logic       alarm;
  logic [4:0] win_count;
  logic [7:0] err_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  drowsy_decision_fsm dut (
    .Clock        (clk),
    .Rst          (rst_n),
    .sample_valid (sample_valid),
    .class_in     (class_in),
    .clear_alarm  (clear_alarm),
    .state        (state),
    .warn         (warn),
    .alarm        (alarm),
    .win_count    (win_count),
    .err_count    (err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame, presented for exactly one rising edge; returns on the following negedge.
  task automatic frame(input logic [2:0] cls, input logic clr);
    sample_valid = 1'b1;
    class_in     = cls;
    clear_alarm  = clr;
    @(negedge clk);
    sample_valid = 1'b0;
    class_in     = 3'b000;
    clear_alarm  = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    class_in     = 3'b000;
    clear_alarm  = 1'b0;
    step(2);
    check("rst_state", state, IDLE);
    check("rst_warn", warn, 1'b0);
    check("rst_alarm", alarm, 1'b0);
    check("rst_win", win_count, 5'd0);
    check("rst_err", err_count, 8'd0);
    rst_n = 1'b1;
    step(1);
    check("idle_hold", state, IDLE);

    // Test 1: first alert frame -> MONITOR after two edges; six drowsy -> WARN.
    frame(F_ALERT, 1'b0);
    check("t1_latency_idle", state, IDLE);
    step(1);
    check("t1_monitor", state, MONITOR);
    for (int i = 0; i < 6; i++) frame(F_DROWSY, 1'b0);
    check("t1_win6", win_count, 5'd6);
    check("t1_warn_latency", warn, 1'b0);
    step(1);
    check("t1_warn", warn, 1'b1);
    check("t1_state_warn", state, WARN);

    // Test 5: sample plus clear in WARN is ignored; drain to count 2 -> MONITOR.
    frame(F_ALERT, 1'b1);
    check("t5_win_hold", win_count, 5'd6);
    step(1);
    check("t5_clear_ignored", state, WARN);
    for (int i = 0; i < 13; i++) frame(F_ALERT, 1'b0);
    check("t5_win2", win_count, 5'd2);
    check("t5_still_warn", state, WARN);
    step(1);
    check("t5_monitor", state, MONITOR);
    check("t5_warn_off", warn, 1'b0);

    // Test 2: five closed frames force ALARM; early clear is rejected at count 5.
    for (int i = 0; i < 5; i++) frame(F_CLOSED, 1'b0);
    check("t2_win5", win_count, 5'd5);
    check("t2_alarm_latency", alarm, 1'b0);
    step(1);
    check("t2_alarm", alarm, 1'b1);
    check("t2_state_alarm", state, ALARM);
    clear_alarm = 1'b1;
    step(1);
    clear_alarm = 1'b0;
    step(1);
    check("t2_clear_rejected", state, ALARM);

    // Test 3: invalid frames only bump the saturating error counter.
    frame(3'b011, 1'b0);
    frame(3'b000, 1'b0);
    check("t3_err2", err_count, 8'd2);
    check("t3_win_unchanged", win_count, 5'd5);
    for (int i = 0; i < 300; i++) frame(3'b111, 1'b0);
    check("t3_err_sat", err_count, 8'd255);
    check("t3_win_still5", win_count, 5'd5);
    check("t3_still_alarm", state, ALARM);

    // Test 4: reach count 10, drain the window, then acknowledge.
    for (int i = 0; i < 5; i++) frame(F_DROWSY, 1'b0);
    check("t4_win10", win_count, 5'd10);
    clear_alarm = 1'b1;
    step(1);
    clear_alarm = 1'b0;
    step(1);
    check("t4_clear_at10", state, ALARM);
    for (int i = 0; i < 16; i++) frame(F_ALERT, 1'b0);
    check("t4_win0", win_count, 5'd0);
    step(1);
    check("t4_clear_not_remembered", state, ALARM);
    clear_alarm = 1'b1;
    step(1);
    clear_alarm = 1'b0;
    check("t4_monitor", state, MONITOR);
    check("t4_alarm_off", alarm, 1'b0);

    // Test 6: reset in the middle of ALARM wipes everything.
    for (int i = 0; i < 5; i++) frame(F_CLOSED, 1'b0);
    step(1);
    check("t6_alarm", alarm, 1'b1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("t6_state_idle", state, IDLE);
    check("t6_alarm_off", alarm, 1'b0);
    check("t6_win0", win_count, 5'd0);
    check("t6_err0", err_count, 8'd0);
    step(3);
    check("t6_stays_idle", state, IDLE);

    // Invalid frame keeps IDLE; a valid closed frame goes only as far as MONITOR.
    frame(3'b110, 1'b0);
    step(1);
    check("idle_invalid_state", state, IDLE);
    check("idle_invalid_err", err_count, 8'd1);
    frame(F_CLOSED, 1'b0);
    step(1);
    check("idle_to_monitor", state, MONITOR);
    check("idle_win1", win_count, 5'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
